seq_det_scheduler: RTL

- Shares one bit-serial Mealy sequence detector (din_bit in, dout_bit out, one bit per clock) between two byte-wide requesters.
- Round-robin arbitration picks a requester. The block clears the detector, shifts the granted word MSB-first into it, and samples the detector output every bit.
- It returns a per-bit match mask and a match count with a valid/ready handshake.
- Sits between producer logic and the detector instance; the detector itself is external.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/bit_serializer.sv | 51 +++++
 rtl/seq_det_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector scheduler.
//   state_t    : scheduler FSM states (IDLE/CLR/SHIFT/DONE)
//   GNT_REQ0/1 : requester indices used for grant and last_grant
//   DATA_W_DEF : default word / mask width
//   CNT_W_DEF  : default match-count width (2**CNT_W > DATA_W)
package seq_det_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 4;

  localparam logic GNT_REQ0 = 1'b0;
  localparam logic GNT_REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-load, MSB-first serializer with a registered serial output.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture data into the shift register
//   step     : present the next bit on bit_out (with load: present data MSB at once)
//   data     : parallel word
//   bit_out  : registered serial bit, 0 whenever neither load+step nor step is active
//   last     : high while the final bit of the word is on bit_out
module bit_serializer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] data,
  output logic              bit_out,
  output logic              last
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg;
  // Number of bits already emitted onto bit_out.
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      idx     <= '0;
      bit_out <= 1'b0;
    end else if (load && step) begin
      bit_out <= data[DATA_W-1];
      sreg    <= data << 1;
      idx     <= IDX_W'(1);
    end else if (load) begin
      sreg    <= data;
      idx     <= '0;
      bit_out <= 1'b0;
    end else if (step) begin
      bit_out <= sreg[DATA_W-1];
      sreg    <= sreg << 1;
      idx     <= idx + IDX_W'(1);
    end else begin
      bit_out <= 1'b0;
    end
  end

  assign last = (idx == IDX_W'(DATA_W));

endmodule

// File: rtl/seq_det_scheduler.sv
// Shares one external bit-serial Mealy detector between two byte requesters.
// Round-robin picks a requester, the word is shifted MSB-first into the
// detector and det_dout is sampled every bit into a match mask and count.
// Build option: define STREAM_MODE_EN to drop the CLR state so detector
// state carries across words (det_rst then stays 0 outside reset).
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   req0_valid/data/ready  : requester 0 (ready = one-cycle accept pulse)
//   req1_valid/data/ready  : requester 1
//   det_rst, det_din       : registered clear and serial bit to the detector
//   det_dout               : detector Mealy output
//   res_valid, res_ready   : result handshake
//   res_grant/mask/count   : result requester, per-bit match mask, ones count
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              det_rst,
  output logic              det_din,
  input  logic              det_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_grant,
  output logic [DATA_W-1:0] res_mask,
  output logic [CNT_W-1:0]  res_count
);

  state_t            state, next_state;
  logic              last_grant;
  logic              grant_any, grant_sel;
  logic              load, step, sample, clr_res, last;
  logic [DATA_W-1:0] load_data;

  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_sel = (req1_valid && (!req0_valid || last_grant == GNT_REQ0)) ? GNT_REQ1 : GNT_REQ0;
    load_data = (grant_sel == GNT_REQ1) ? req1_data : req0_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (grant_any) begin
`ifdef STREAM_MODE_EN
        next_state = SHIFT;
`else
        next_state = CLR;
`endif
      end
      CLR:   next_state = SHIFT;
      SHIFT: if (last) next_state = DONE;
      DONE:  if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The serializer advances one step ahead of sampling: the step issued in
  // CLR (or with the load in stream mode) puts the MSB on det_din for SHIFT
  // cycle 0, and 'last' marks the cycle carrying the LSB.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    sample     = 1'b0;
    clr_res    = 1'b0;
    case (state)
      IDLE: if (grant_any) begin
        req0_ready = !rst && (grant_sel == GNT_REQ0);
        req1_ready = !rst && (grant_sel == GNT_REQ1);
        load       = 1'b1;
`ifdef STREAM_MODE_EN
        step       = 1'b1;
        clr_res    = 1'b1;
`endif
      end
      CLR: begin
        step    = 1'b1;
        clr_res = 1'b1;
      end
      SHIFT: begin
        sample = 1'b1;
        step   = !last;
      end
      default: ;
    endcase
  end

  bit_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .data    (load_data),
    .bit_out (det_din),
    .last    (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_rst    <= 1'b0;
      res_valid  <= 1'b0;
      res_grant  <= GNT_REQ0;
      res_mask   <= '0;
      res_count  <= '0;
      last_grant <= GNT_REQ1;
    end else begin
      det_rst   <= (next_state == CLR);
      res_valid <= (next_state == DONE);
      if (load) res_grant <= grant_sel;
      if (clr_res) begin
        res_mask  <= '0;
        res_count <= '0;
      end else if (sample) begin
        // First sampled bit ends up in the MSB after DATA_W shifts.
        res_mask  <= {res_mask[DATA_W-2:0], det_dout};
        res_count <= res_count + CNT_W'(det_dout);
      end
      if (state == DONE && res_ready) last_grant <= res_grant;
    end
  end

endmodule
